reg_file_param: RTL and testbench

- Parametrised register file built from edge-triggered storage. It replaces per-bit latch/flip-flop instances in the simple processor datapath.
- Provides DEPTH words of WIDTH bits, one synchronous write port and two registered read ports.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Sits between instruction decode (register addresses) and the ALU operand muxes.

---
 rtl/reg_file_param.sv | 88 ++++++++
 tb/tb_reg_file_param.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file: DEPTH x WIDTH flop storage, one synchronous write
// port, two registered read ports with optional write bypass and hardwired r0.
module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AW       = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr1,
  input  logic [AW-1:0]    rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             rd_valid
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data [2];
  logic             r_rd_valid;

  logic [DEPTH-1:0] w_wr_sel;
  logic [AW-1:0]    w_rd_addr [2];
  logic [WIDTH-1:0] w_rd_next [2];

  assign w_rd_addr[0] = rd_addr1;
  assign w_rd_addr[1] = rd_addr2;

  // Per-register write decode; r0 is never selected when it is hardwired to zero.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
    if (ZERO_REG != 0 && gi == 0) begin : g_zero
      assign w_wr_sel[gi] = 1'b0;
    end else begin : g_norm
      assign w_wr_sel[gi] = wr_en && (wr_addr == AW'(gi));
    end
  end

  // Read mux per port: bypass takes the in-flight write, zero register wins over everything.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    always_comb begin
      w_rd_next[gi] = r_mem[w_rd_addr[gi]];
      if (BYPASS != 0 && wr_en && (w_rd_addr[gi] == wr_addr)) begin
        w_rd_next[gi] = wr_data;
      end
      if (ZERO_REG != 0 && (w_rd_addr[gi] == '0)) begin
        w_rd_next[gi] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_sel[i]) begin
          r_mem[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data[0] <= '0;
      r_rd_data[1] <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) begin
        r_rd_data[0] <= w_rd_next[0];
        r_rd_data[1] <= w_rd_next[1];
      end
    end
  end

  assign rd_data1 = r_rd_data[0];
  assign rd_data2 = r_rd_data[1];
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench: three configurations of reg_file_param driven in lockstep,
// checked against a hand-written vector table and an array-based reference model.
module tb_reg_file_param;

  localparam int NCFG = 3;
  localparam int CFG_BYPASS [NCFG] = '{1, 0, 1};
  localparam int CFG_ZERO   [NCFG] = '{0, 0, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [2:0] rd_addr1 = '0;
  logic [2:0] rd_addr2 = '0;

  logic [7:0] o_d1 [NCFG];
  logic [7:0] o_d2 [NCFG];
  logic       o_v  [NCFG];

  int checks = 0;
  int errors = 0;

  // model state
  logic [7:0] m_mem [NCFG][8];
  logic [7:0] m_d1  [NCFG];
  logic [7:0] m_d2  [NCFG];
  logic       m_v   [NCFG];

  always #5 clk = ~clk;

  reg_file_param #(.WIDTH(8), .DEPTH(8), .AW(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(o_d1[0]), .rd_data2(o_d2[0]), .rd_valid(o_v[0]));

  reg_file_param #(.WIDTH(8), .DEPTH(8), .AW(3), .BYPASS(0), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(o_d1[1]), .rd_data2(o_d2[1]), .rd_valid(o_v[1]));

  reg_file_param #(.WIDTH(8), .DEPTH(8), .AW(3), .BYPASS(1), .ZERO_REG(1)) dut_c (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(o_d1[2]), .rd_data2(o_d2[2]), .rd_valid(o_v[2]));

  typedef struct {
    logic       rst;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] e_d1;
    logic [7:0] e_d2;
    logic       e_v;
  } vec_t;

  task automatic chk(input string name, input int cfg, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d: got %h expected %h", name, cfg, act, exp);
    end
  endtask

  // Reference: whole-file semantics from the rules, one call per clock edge.
  function automatic logic [7:0] model_read(input int c, input logic [2:0] ra,
                                            input logic we, input logic [2:0] wa,
                                            input logic [7:0] wd);
    logic [7:0] v;
    if (CFG_ZERO[c] != 0 && ra == 3'd0) return 8'h00;
    v = m_mem[c][ra];
    if (CFG_BYPASS[c] != 0 && we && ra == wa) v = wd;
    return v;
  endfunction

  task automatic model_step(input logic rst, input logic we, input logic [2:0] wa,
                            input logic [7:0] wd, input logic re,
                            input logic [2:0] ra1, input logic [2:0] ra2);
    for (int c = 0; c < NCFG; c++) begin
      if (rst) begin
        for (int i = 0; i < 8; i++) m_mem[c][i] = 8'h00;
        m_d1[c] = 8'h00;
        m_d2[c] = 8'h00;
        m_v[c]  = 1'b0;
      end else begin
        m_v[c] = re;
        if (re) begin
          m_d1[c] = model_read(c, ra1, we, wa, wd);
          m_d2[c] = model_read(c, ra2, we, wa, wd);
        end
        if (we && !(CFG_ZERO[c] != 0 && wa == 3'd0)) m_mem[c][wa] = wd;
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare every configuration.
  task automatic step(input string tag, input logic rst, input logic we, input logic [2:0] wa,
                      input logic [7:0] wd, input logic re,
                      input logic [2:0] ra1, input logic [2:0] ra2);
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr1 = ra1; rd_addr2 = ra2;
    @(posedge clk);
    #1;
    model_step(rst, we, wa, wd, re, ra1, ra2);
    for (int c = 0; c < NCFG; c++) begin
      chk({tag, ".d1"}, c, o_d1[c], m_d1[c]);
      chk({tag, ".d2"}, c, o_d2[c], m_d2[c]);
      chk({tag, ".v"},  c, {7'd0, o_v[c]}, {7'd0, m_v[c]});
    end
    $display("txn %-8s rst=%0d we=%0d wa=%0d wd=%h re=%0d ra=%0d/%0d -> a:%h/%h/%0d b:%h/%h/%0d c:%h/%h/%0d",
             tag, rst, we, wa, wd, re, ra1, ra2,
             o_d1[0], o_d2[0], o_v[0], o_d1[1], o_d2[1], o_v[1], o_d1[2], o_d2[2], o_v[2]);
  endtask

  vec_t vecs [14];

  initial begin
    // expectations for the BYPASS=1, ZERO_REG=0 configuration
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'd3, 8'h5C, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd6, 8'hF1, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 3'd6, 8'h5C, 8'hF1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd0, 8'h5C, 8'hF1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 3'd3, 8'h22, 8'h5C, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd2, 8'h22, 8'h22, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 3'd5, 8'h99, 1'b1, 3'd5, 3'd5, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 3'd2, 8'h00, 8'h00, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 3'd0, 8'h7E, 1'b1, 3'd0, 3'd0, 8'h7E, 8'h7E, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 3'd0, 8'h01, 1'b0, 3'd0, 3'd0, 8'h7E, 8'h7E, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'd0, 8'h02, 1'b0, 3'd0, 3'd0, 8'h7E, 8'h7E, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 3'd0, 8'h03, 1'b0, 3'd0, 3'd0, 8'h7E, 8'h7E, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd1, 8'h03, 8'h00, 1'b1};

    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
           vecs[i].re, vecs[i].ra1, vecs[i].ra2);
      chk($sformatf("tbl%0d.d1", i), 0, o_d1[0], vecs[i].e_d1);
      chk($sformatf("tbl%0d.d2", i), 0, o_d2[0], vecs[i].e_d2);
      chk($sformatf("tbl%0d.v", i),  0, {7'd0, o_v[0]}, {7'd0, vecs[i].e_v});
    end

    // BYPASS=0 collision: old value first, new value on the following read
    step("col_wr", 1'b0, 1'b1, 3'd2, 8'h11, 1'b0, 3'd0, 3'd0);
    step("col_hit", 1'b0, 1'b1, 3'd2, 8'h22, 1'b1, 3'd2, 3'd2);
    chk("nobyp_old", 1, o_d1[1], 8'h11);
    chk("byp_new",   0, o_d1[0], 8'h22);
    step("col_aft", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2, 3'd0);
    chk("nobyp_new", 1, o_d1[1], 8'h22);

    // zero register: write then read, and same-cycle bypass attempt
    step("z_wr", 1'b0, 1'b1, 3'd0, 8'h7E, 1'b0, 3'd0, 3'd0);
    step("z_rd", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 3'd0);
    chk("zero_rd1", 2, o_d1[2], 8'h00);
    chk("zero_rd2", 2, o_d2[2], 8'h00);
    step("z_byp", 1'b0, 1'b1, 3'd0, 8'h7E, 1'b1, 3'd0, 3'd0);
    chk("zero_byp", 2, o_d1[2], 8'h00);

    // fill with 0xAA, reset, read everything back as zero
    for (int i = 0; i < 8; i++) step("fill", 1'b0, 1'b1, 3'(i), 8'hAA, 1'b0, 3'd0, 3'd0);
    step("rst", 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 3'd2);
    chk("rst_valid", 0, {7'd0, o_v[0]}, 8'h00);
    for (int i = 0; i < 8; i += 2) begin
      step("rd_rst", 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'(i), 3'(i + 1));
      chk("rst_clear1", 1, o_d1[1], 8'h00);
      chk("rst_clear2", 1, o_d2[1], 8'h00);
    end

    // randomized traffic, biased toward collisions
    for (int n = 0; n < 400; n++) begin
      logic [2:0] wa;
      logic [2:0] ra1;
      logic [2:0] ra2;
      wa  = 3'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), wa,
           8'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0), ra1, ra2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
